// File: rtl/serial_tx_cfg.sv
// serial_tx_cfg: parametrised UART transmitter (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with a line-break request and a completion strobe.
// Handshake: a word is accepted when i_wr is high while o_busy is low (and not
// in reset); o_busy then stays high for the whole frame and i_wr is ignored.
// o_done pulses for one cycle as the frame ends, and a new i_wr is accepted on
// that same cycle. The FSM state is visible as state_q for checkers.
module serial_tx_cfg #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_break,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_tx
);

    localparam int BAUD_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CW        = (BAUD_CLKS < 2) ? 1 : $clog2(BAUD_CLKS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(BAUD_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    generate
        if (BAUD_CLKS < 2) begin : g_bad_baud
            $error("serial_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("serial_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("serial_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("serial_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d, done_d;
    logic                 tick;

    assign tick = (cnt_q == '0);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = o_tx;
        busy_d  = o_busy;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = !i_break;
                busy_d = 1'b0;
                if (i_wr) begin
                    // Capture word and parity now so later i_data changes are harmless.
                    state_d = S_START;
                    cnt_d   = CNT_MAX;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    sh_d    = i_data;
                    par_d   = (^i_data) ^ (PARITY == 1);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = CNT_MAX;
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            tx_d    = sh_q[0];
                        end
                        S_DATA: begin
                            if (bit_q == LAST_DATA) begin
                                if (PARITY != 0) begin
                                    state_d = S_PARITY;
                                    tx_d    = par_q;
                                end else begin
                                    state_d = S_STOP;
                                    tx_d    = 1'b1;
                                end
                            end else begin
                                bit_d = bit_q + 4'd1;
                                sh_d  = sh_q >> 1;
                                tx_d  = sh_q[1];
                            end
                        end
                        S_PARITY: begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                        default: begin
                            if (stop_q == STOP_LAST) begin
                                // Frame ends: drop busy, strobe done, line back to idle level.
                                state_d = S_IDLE;
                                cnt_d   = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                tx_d    = !i_break;
                            end else begin
                                stop_d = 1'b1;
                                tx_d   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            o_tx    <= tx_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
        end
    end

endmodule
